// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and the decode taps
// that read fields out of the instruction register.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB       = 0;
  localparam int OP_MSB       = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7B5_BIT = 30;

endpackage

// File: rtl/pc_nextsel.sv
// Combinational next-PC select: sequential +4 or branch/jump target.
// FETCH_MISALIGN_CHECK_EN keeps the target unmodified and flags misalignment.
module pc_nextsel (
  input  logic [31:0] pc_i,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] pc_next_o,
  output logic        misalign_o
);

  // 32-bit add wraps naturally past 0xFFFF_FFFC.
  assign pc_plus4_o = pc_i + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign pc_next_o  = pc_src_i ? pc_target_i : pc_plus4_o;
  assign misalign_o = pc_src_i & (|pc_target_i[1:0]);
`else
  assign pc_next_o  = pc_src_i ? (pc_target_i & 32'hFFFF_FFFC) : pc_plus4_o;
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: PC, request/grant/response imem port, instruction register.
// FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-target fault state.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_next;
  logic         misalign;

  pc_nextsel u_pc_nextsel (
    .pc_i        (pc_q),
    .pc_src_i    (pc_src),
    .pc_target_i (pc_target),
    .pc_plus4_o  (pc_plus4),
    .pc_next_o   (pc_next),
    .misalign_o  (misalign)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = pc_next;
          state_d = ST_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (misalign) begin
            err_d   = 1'b1;
            state_d = ST_FAULT;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_err = err_q;
`else
  // Tied low: pc_nextsel drives a constant 0 in this build.
  assign misalign_err = misalign;
`endif

endmodule
